fetch_stage: RTL and testbench

// - RV32I fetch stage, directly upstream of the decode/execute stage.
// - Holds PC and runs a single-outstanding req/ack handshake to instruction memory.
// - Redirects on a resolved branch from execute.
// - Owns the IF/ID pipeline register that drives instrD/PCD into decode.

---
 rtl/rv32i_pkg.sv | 26 ++
 rtl/fetch_stage.sv | 141 ++++++++++++++
 tb/tb_fetch_stage.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/rv32i_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rv32i_pkg : shared RV32I datapath constants and fetch-stage types    |
// | Revision  : 1.0                                                      |
// +--------------------------------------------------------------------+
package rv32i_pkg;

  localparam int DPW = 32;

  // addi x0, x0, 0 -- the canonical bubble placed in IF/ID
  localparam logic [DPW-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_HOLD = 2'd2,
    S_DROP = 2'd3
  } fetch_state_t;

  // Sequential PC increment; wraps silently at 2^32
  function automatic logic [DPW-1:0] pc_incr(input logic [DPW-1:0] pc);
    return pc + 32'd4;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fetch_stage : RV32I PC, single-outstanding imem handshake, IF/ID reg |
// | Revision    : 1.0                                                    |
// +--------------------------------------------------------------------+
module fetch_stage
  import rv32i_pkg::*;
#(
  parameter logic [DPW-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic           clk,
  input  logic           arst_n,
  input  logic           stallD,
  input  logic           flushD,
  input  logic           pcsrcE,
  input  logic [DPW-1:0] pc_targetE,
  output logic           imem_req,
  output logic [DPW-1:0] imem_addr,
  input  logic           imem_ack,
  input  logic [DPW-1:0] imem_rdata,
  output logic [DPW-1:0] instrD,
  output logic [DPW-1:0] PCD,
  output logic [DPW-1:0] PCPlus4D,
  output logic           validD
);

  fetch_state_t   state;
  logic [DPW-1:0] pc_f;
  logic [DPW-1:0] instr_buf;
  logic [DPW-1:0] redir_pc;

  logic           accepted;
  logic           deliver;
  logic [DPW-1:0] deliver_word;
  logic [DPW-1:0] pc_plus4;

  // A flushed instruction still counts as consumed by decode
  assign accepted  = flushD | ~stallD;
  assign pc_plus4  = pc_incr(pc_f);
  assign imem_addr = pc_f;

  // Redirects always beat delivery in the same cycle
  always_comb begin
    deliver      = 1'b0;
    deliver_word = imem_rdata;
    unique case (state)
      S_REQ:  deliver = imem_ack & ~pcsrcE & accepted;
      S_HOLD: begin
        deliver      = ~pcsrcE & accepted;
        deliver_word = instr_buf;
      end
      default: deliver = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state     <= S_IDLE;
      pc_f      <= RESET_PC;
      instr_buf <= NOP_INSTR;
      redir_pc  <= '0;
      imem_req  <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          state    <= S_REQ;
          imem_req <= 1'b1;
        end
        S_REQ: begin
          if (imem_ack) begin
            if (pcsrcE) begin
              pc_f <= pc_targetE;
            end else if (accepted) begin
              pc_f <= pc_plus4;
            end else begin
              instr_buf <= imem_rdata;
              state     <= S_HOLD;
              imem_req  <= 1'b0;
            end
          end else if (pcsrcE) begin
            // Address must stay put until memory answers; remember the target
            redir_pc <= pc_targetE;
            state    <= S_DROP;
          end
        end
        S_HOLD: begin
          if (pcsrcE) begin
            pc_f     <= pc_targetE;
            state    <= S_REQ;
            imem_req <= 1'b1;
          end else if (accepted) begin
            pc_f     <= pc_plus4;
            state    <= S_REQ;
            imem_req <= 1'b1;
          end
        end
        S_DROP: begin
          if (imem_ack) begin
            pc_f  <= pcsrcE ? pc_targetE : redir_pc;
            state <= S_REQ;
          end else if (pcsrcE) begin
            redir_pc <= pc_targetE;
          end
        end
        default: begin
          state    <= S_IDLE;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

  // IF/ID register: flush > stall > load (bubble when nothing delivered)
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      instrD   <= NOP_INSTR;
      PCD      <= '0;
      PCPlus4D <= '0;
      validD   <= 1'b0;
    end else if (flushD) begin
      instrD   <= NOP_INSTR;
      PCD      <= '0;
      PCPlus4D <= '0;
      validD   <= 1'b0;
    end else if (!stallD) begin
      if (deliver) begin
        instrD   <= deliver_word;
        PCD      <= pc_f;
        PCPlus4D <= pc_plus4;
        validD   <= 1'b1;
      end else begin
        instrD   <= NOP_INSTR;
        PCD      <= '0;
        PCPlus4D <= '0;
        validD   <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_fetch_stage : directed stimulus with queued IF/ID expectations    |
// | Revision       : 1.0                                                 |
// +--------------------------------------------------------------------+
module tb_fetch_stage;
  import rv32i_pkg::*;

  logic        clk = 1'b0;
  logic        arst_n;
  logic        stallD, flushD, pcsrcE, imem_ack;
  logic [31:0] pc_targetE;
  logic        imem_req;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] instrD, PCD, PCPlus4D;
  logic        validD;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h5A00_0000 | a;
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk        (clk),
    .arst_n     (arst_n),
    .stallD     (stallD),
    .flushD     (flushD),
    .pcsrcE     (pcsrcE),
    .pc_targetE (pc_targetE),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .instrD     (instrD),
    .PCD        (PCD),
    .PCPlus4D   (PCPlus4D),
    .validD     (validD)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic push(input logic [31:0] pc);
    exp_t e;
    e.instr = mem_word(pc);
    e.pc    = pc;
    exp_q.push_back(e);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Monitor: any edge that loaded a real instruction must match the queue head
  always @(posedge clk) begin
    logic load_edge;
    exp_t e;
    load_edge = arst_n & ~stallD & ~flushD;
    #1;
    if (load_edge && arst_n && validD) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_delivery: got pc %h with nothing expected", PCD);
      end else begin
        e = exp_q.pop_front();
        check("ifid_instr", instrD, e.instr);
        check("ifid_pc", PCD, e.pc);
        check("ifid_pc4", PCPlus4D, e.pc + 32'd4);
      end
    end
  end

  task automatic check_bubble(input string name);
    check({name, "_valid"}, {31'd0, validD}, 32'd0);
    check({name, "_instr"}, instrD, NOP_INSTR);
    check({name, "_pc"}, PCD, 32'd0);
  endtask

  initial begin
    arst_n = 1'b1; stallD = 1'b0; flushD = 1'b0; pcsrcE = 1'b0;
    pc_targetE = '0; imem_ack = 1'b0;
    #1 arst_n = 1'b0;
    cyc(); cyc();
    check("rst_req", {31'd0, imem_req}, 32'd0);
    check_bubble("rst");
    check("rst_pc4", PCPlus4D, 32'd0);
    arst_n = 1'b1;
    check("idle_req", {31'd0, imem_req}, 32'd0);

    // Zero-wait streaming from reset
    cyc();
    check("req0", {31'd0, imem_req}, 32'd1);
    check("addr0", imem_addr, 32'h0);
    push(32'h0); imem_ack = 1'b1;
    cyc(); check("addr4", imem_addr, 32'h4); push(32'h4);
    cyc(); check("addr8", imem_addr, 32'h8);

    // Three wait states at 0x8: address stable, IF/ID bubbles
    imem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("wait_addr", imem_addr, 32'h8);
      check("wait_req", {31'd0, imem_req}, 32'd1);
      check_bubble("wait");
    end
    imem_ack = 1'b1; push(32'h8);
    cyc(); check("addrC", imem_addr, 32'hC); push(32'hC);
    cyc(); check("addr10", imem_addr, 32'h10);

    // Stall on ack of 0x10: HOLD with request dropped, IF/ID frozen
    stallD = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cyc();
      check("hold_req", {31'd0, imem_req}, 32'd0);
      check("hold_pc", PCD, 32'hC);
      check("hold_instr", instrD, mem_word(32'hC));
      check("hold_valid", {31'd0, validD}, 32'd1);
    end
    stallD = 1'b0; push(32'h10);
    cyc();
    check("post_hold_req", {31'd0, imem_req}, 32'd1);
    check("post_hold_addr", imem_addr, 32'h14);
    push(32'h14);
    cyc(); check("addr18", imem_addr, 32'h18); push(32'h18);
    cyc(); check("addr1C", imem_addr, 32'h1C); push(32'h1C);
    cyc(); check("addr20", imem_addr, 32'h20);

    // Redirect while 0x20 is outstanding
    imem_ack = 1'b0; pcsrcE = 1'b1; pc_targetE = 32'h100;
    cyc(); pcsrcE = 1'b0; pc_targetE = '0;
    check("drop_addr_a", imem_addr, 32'h20);
    check("drop_req", {31'd0, imem_req}, 32'd1);
    cyc(); check("drop_addr_b", imem_addr, 32'h20);
    imem_ack = 1'b1;
    cyc(); check("redir_addr", imem_addr, 32'h100); push(32'h100);
    cyc(); check("addr104", imem_addr, 32'h104);

    // Redirect + flush on ack cycles of 0x104 and then 0x30
    pcsrcE = 1'b1; flushD = 1'b1; pc_targetE = 32'h30;
    cyc(); pcsrcE = 1'b0; flushD = 1'b0;
    check("jmp_addr30", imem_addr, 32'h30);
    check_bubble("flush_a");
    pcsrcE = 1'b1; flushD = 1'b1; pc_targetE = 32'h3C;
    cyc(); pcsrcE = 1'b0; flushD = 1'b0; pc_targetE = '0;
    check("jmp_addr3C", imem_addr, 32'h3C);
    check_bubble("flush_b");
    push(32'h3C);
    cyc(); check("addr40", imem_addr, 32'h40);

    // Asynchronous reset mid-request at 0x40
    imem_ack = 1'b0;
    #2 arst_n = 1'b0;
    #1;
    check("arst_req", {31'd0, imem_req}, 32'd0);
    check("arst_addr", imem_addr, 32'h0);
    check_bubble("arst");
    check("arst_pc4", PCPlus4D, 32'd0);
    #1 arst_n = 1'b1;
    check("arst_queue", 32'(exp_q.size()), 32'd0);
    cyc();
    check("rel_req", {31'd0, imem_req}, 32'd1);
    check("rel_addr", imem_addr, 32'h0);
    imem_ack = 1'b1; push(32'h0);
    cyc(); check("rel_addr4", imem_addr, 32'h4);
    imem_ack = 1'b0;
    cyc(); cyc();
    check("final_queue", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
